turn_action_ctrl: RTL and testbench
===================================

Name: turn_action_ctrl

Overview:
- Game-logic sequencer for the 20x15 tile battle map (32x32 px tiles, tile index pos = x + 20*y, 0..299).
- Turns player button pulses into cursor movement, unit selection, moves and attacks for two units (knight, wizard). Turns alternate between the two units.
- Drives the renderer's selected_pos, knight_pos, wizard_pos, per-unit animation frame numbers and HP.
- Replaces the renderer's fixed positions and free-running idle animation.

Parameters:
- HP_INIT, 10, starting HP for both units.
- MOVE_RANGE, 3, maximum Manhattan move distance.
- KNIGHT_RANGE, 1, knight attack range.
- WIZARD_RANGE, 3, wizard attack range.
- KNIGHT_DMG, 3, damage dealt by the knight.
- WIZARD_DMG, 2, damage dealt by the wizard.
- TICKS_PER_FRAME, 4, anim_tick pulses per attack frame.

Ports:
- clk_25MHz  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- anim_tick  in  1  single-cycle animation pulse, synchronous to clk_25MHz.
- btn_up, btn_down, btn_left, btn_right, btn_ok, btn_cancel  in  1 each  debounced one-pulse buttons.
- selected_pos  out  9  cursor tile.
- knight_pos  out  9  knight tile.
- wizard_pos  out  9  wizard tile.
- knight_anim  out  3  knight sprite frame.
- wizard_anim  out  3  wizard sprite frame.
- knight_hp  out  4  knight HP.
- wizard_hp  out  4  wizard HP.
- turn  out  1  active unit: 0 = knight, 1 = wizard.
- invalid  out  1  one-cycle pulse on a rejected command.
- game_over  out  1  high once either unit's HP reaches 0.
- winner  out  1  winning unit, valid while game_over = 1.

Behaviour:
- Reset values (asynchronous, rst=0):
  - selected_pos=125, knight_pos=125, wizard_pos=167.
  - turn=0, both HP=HP_INIT, anims=0.
  - invalid=0, game_over=0, winner=0.
  - State=CURSOR; anim_cnt (4b) and tick_cnt cleared.
- All outputs are registered.
- anim_cnt increments on every anim_tick, wraps 15->0.
- Idle frame: 0 while anim_cnt<8, otherwise 1.
- Button priority within one cycle: cancel > ok > up > down > left > right. At most one action per cycle.
- Cursor moves one tile per pulse. It clamps at grid edges (x 0..19, y 0..14) with no wrap; a press at an edge leaves selected_pos unchanged.
- State machine:
  - CURSOR
    - Arrow keys move the cursor.
    - ok on the active unit's tile -> UNIT_SEL. Record src = that tile.
    - ok elsewhere -> invalid pulse, no state change.
    - cancel: ignored.
  - UNIT_SEL
    - Arrow keys move the cursor; cancel -> CURSOR (cursor unchanged).
    - On ok, let d = Manhattan(src, cursor):
      - cursor == src -> END_TURN (wait).
      - cursor == enemy tile and d <= the active unit's range -> ATTACK.
      - cursor is an empty tile, d <= MOVE_RANGE, and the enemy tile is not on the x-first-then-y L-path -> MOVE. Record dst.
      - Anything else -> invalid pulse, stay in UNIT_SEL.
  - MOVE
    - Each anim_tick steps the active unit's position one tile toward dst: x first, then y.
    - On the tick that reaches dst -> END_TURN.
    - Latency is d ticks.
  - ATTACK
    - Active unit's anim = 2,3,4,5, each held TICKS_PER_FRAME ticks (16 ticks total). tick_cnt is cleared on entry.
    - After the 16th tick, enemy HP -= attacker damage, saturating at 0.
    - If the result is 0 -> GAME_OVER; otherwise -> END_TURN.
  - END_TURN
    - Lasts one cycle. Toggles turn, sets selected_pos to the new active unit's tile, -> CURSOR.
  - GAME_OVER
    - game_over=1, winner = attacker. All buttons ignored until reset.
- During MOVE and ATTACK, all buttons are ignored (no invalid pulse).
- The non-attacking unit always shows the idle frame. Both units show idle frames outside ATTACK.
- anim_tick and a button in the same cycle: the tick is processed per the current state; the button is ignored in MOVE and ATTACK.
- Reset asserted mid-MOVE or mid-ATTACK restores all reset values immediately. No partial HP update survives.

Decomposition:
- Package turn_ctrl_pkg holds:
  - Grid constants GRID_W=20, GRID_H=15.
  - State enum: CURSOR, UNIT_SEL, MOVE, ATTACK, END_TURN, GAME_OVER.
  - Unit id constants and the reset-position constants.
- One combinational sub-module, grid_path_check. It converts tiles to (x, y) and outputs the Manhattan distance and an enemy-on-L-path flag. Instantiate it once, for src/cursor/enemy.

Test Plan:
- Reset -> selected_pos=125, knight_pos=125, wizard_pos=167, hp=10/10, turn=0, anims follow the anim_cnt idle pattern (0 while anim_cnt<8, else 1).
- Cursor clamp: cursor at (0,0), pulse left then up -> selected_pos stays 0. Cursor at 299, pulse right/down -> stays 299.
- Knight move:
  - Stimulus: ok@125, right, right, down, ok (dst 147).
  - Response: after 3 anim_ticks knight_pos goes 126 -> 127 -> 147.
  - Then END_TURN: turn=1, selected_pos=167.
- Invalid commands:
  - Stimulus: wizard turn with knight at 125; ok@167, cursor to 125 (d=4 > WIZARD_RANGE=3), ok.
  - Response: invalid=1 for one cycle, state stays UNIT_SEL, positions unchanged.
  - Then cancel -> CURSOR; ok@0 -> invalid.
- Attack:
  - Stimulus: knight at 147, wizard at 167; ok@147, down, ok.
  - Response: knight_anim = 2,3,4,5 over 16 ticks; wizard_hp 10 -> 7; turn -> 1.
  - Repeat until wizard_hp = 0 (10 -> 7 -> 4 -> 1 -> 0, the last hit saturating) -> game_over=1, winner=0, buttons ignored.
- Reset mid-ATTACK (tick 9): rst=0 -> all reset values on the next sample. Wizard HP is unchanged at 10.

Source files
------------

// File: rtl/turn_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : turn_ctrl_pkg                                            |
// | Description : Shared constants, state encoding and tile helpers for    |
// |               the turn/action sequencer of the 20x15 battle map.       |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package turn_ctrl_pkg;

  localparam int GRID_W = 20;
  localparam int GRID_H = 15;

  typedef enum logic [2:0] {
    CURSOR    = 3'd0,
    UNIT_SEL  = 3'd1,
    MOVE      = 3'd2,
    ATTACK    = 3'd3,
    END_TURN  = 3'd4,
    GAME_OVER = 3'd5
  } state_t;

  localparam logic UNIT_KNIGHT = 1'b0;
  localparam logic UNIT_WIZARD = 1'b1;

  localparam logic [8:0] CURSOR_POS_RST = 9'd125;
  localparam logic [8:0] KNIGHT_POS_RST = 9'd125;
  localparam logic [8:0] WIZARD_POS_RST = 9'd167;

  // Tile index -> column (0..19)
  function automatic logic [4:0] tile_x(input logic [8:0] pos);
    return 5'(pos % 9'(GRID_W));
  endfunction

  // Tile index -> row (0..14)
  function automatic logic [3:0] tile_y(input logic [8:0] pos);
    return 4'(pos / 9'(GRID_W));
  endfunction

endpackage
`default_nettype wire

// File: rtl/turn_action_ctrl_path_check.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : grid_path_check                                          |
// | Description : Combinational geometry helper. Gives the Manhattan       |
// |               distance src->cursor and whether the enemy tile lies on  |
// |               the x-first-then-y L-shaped path from src to cursor.     |
// | Ports       : i_src, i_cursor, i_enemy  tile indices (9b)              |
// |               o_dist                    Manhattan distance (6b)        |
// |               o_enemy_on_path           enemy on the L-path            |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module grid_path_check
  import turn_ctrl_pkg::*;
(
  input  logic [8:0] i_src,
  input  logic [8:0] i_cursor,
  input  logic [8:0] i_enemy,
  output logic [5:0] o_dist,
  output logic       o_enemy_on_path
);

  logic [4:0] w_sx, w_cx, w_ex, w_dx, w_xlo, w_xhi;
  logic [3:0] w_sy, w_cy, w_ey, w_dy, w_ylo, w_yhi;
  logic       w_on_x_leg, w_on_y_leg;

  assign w_sx = tile_x(i_src);
  assign w_sy = tile_y(i_src);
  assign w_cx = tile_x(i_cursor);
  assign w_cy = tile_y(i_cursor);
  assign w_ex = tile_x(i_enemy);
  assign w_ey = tile_y(i_enemy);

  assign w_xlo = (w_sx < w_cx) ? w_sx : w_cx;
  assign w_xhi = (w_sx < w_cx) ? w_cx : w_sx;
  assign w_ylo = (w_sy < w_cy) ? w_sy : w_cy;
  assign w_yhi = (w_sy < w_cy) ? w_cy : w_sy;

  assign w_dx = w_xhi - w_xlo;
  assign w_dy = w_yhi - w_ylo;
  assign o_dist = 6'(w_dx) + 6'(w_dy);

  // Horizontal leg runs along the source row, vertical leg along the
  // destination column; endpoints are included.
  assign w_on_x_leg = (w_ey == w_sy) && (w_ex >= w_xlo) && (w_ex <= w_xhi);
  assign w_on_y_leg = (w_ex == w_cx) && (w_ey >= w_ylo) && (w_ey <= w_yhi);
  assign o_enemy_on_path = w_on_x_leg | w_on_y_leg;

endmodule
`default_nettype wire

// File: rtl/turn_action_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : turn_action_ctrl                                         |
// | Description : Turn-based action sequencer for a knight and a wizard.   |
// |               Button pulses move the cursor, select the active unit    |
// |               and issue move/attack/wait commands; anim_tick paces     |
// |               movement and attack animation.                           |
// | Ports       : clk_25MHz, rst (async, active-low), anim_tick            |
// |               btn_up/down/left/right/ok/cancel   one-pulse buttons     |
// |               selected_pos, knight_pos, wizard_pos  tiles (9b)         |
// |               knight_anim, wizard_anim  sprite frames (3b)             |
// |               knight_hp, wizard_hp  hit points (4b)                    |
// |               turn, invalid, game_over, winner                         |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module turn_action_ctrl
  import turn_ctrl_pkg::*;
#(
  parameter int HP_INIT         = 10,
  parameter int MOVE_RANGE      = 3,
  parameter int KNIGHT_RANGE    = 1,
  parameter int WIZARD_RANGE    = 3,
  parameter int KNIGHT_DMG      = 3,
  parameter int WIZARD_DMG      = 2,
  parameter int TICKS_PER_FRAME = 4
) (
  input  logic       clk_25MHz,
  input  logic       rst,
  input  logic       anim_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_ok,
  input  logic       btn_cancel,
  output logic [8:0] selected_pos,
  output logic [8:0] knight_pos,
  output logic [8:0] wizard_pos,
  output logic [2:0] knight_anim,
  output logic [2:0] wizard_anim,
  output logic [3:0] knight_hp,
  output logic [3:0] wizard_hp,
  output logic       turn,
  output logic       invalid,
  output logic       game_over,
  output logic       winner
);

  // Four attack frames (2..5), each held TICKS_PER_FRAME ticks
  localparam int         c_attack_ticks  = 4 * TICKS_PER_FRAME;
  localparam logic [7:0] c_last_tick     = 8'(c_attack_ticks - 1);
  localparam logic [3:0] c_hp_init       = 4'(HP_INIT);
  localparam logic [3:0] c_knight_dmg    = 4'(KNIGHT_DMG);
  localparam logic [3:0] c_wizard_dmg    = 4'(WIZARD_DMG);
  localparam logic [5:0] c_knight_range  = 6'(KNIGHT_RANGE);
  localparam logic [5:0] c_wizard_range  = 6'(WIZARD_RANGE);
  localparam logic [5:0] c_move_range    = 6'(MOVE_RANGE);

  state_t     r_state, w_state_nxt;
  logic       r_turn, w_turn_nxt;
  logic [8:0] r_selected_pos, w_selected_pos_nxt;
  logic [8:0] r_knight_pos, w_knight_pos_nxt;
  logic [8:0] r_wizard_pos, w_wizard_pos_nxt;
  logic [8:0] r_src, w_src_nxt;
  logic [8:0] r_dst, w_dst_nxt;
  logic [3:0] r_knight_hp, w_knight_hp_nxt;
  logic [3:0] r_wizard_hp, w_wizard_hp_nxt;
  logic [3:0] r_anim_cnt, w_anim_cnt_nxt;
  logic [7:0] r_tick_cnt, w_tick_cnt_nxt;
  logic [2:0] r_knight_anim, w_knight_anim_nxt;
  logic [2:0] r_wizard_anim, w_wizard_anim_nxt;
  logic       r_invalid, w_invalid_nxt;
  logic       r_game_over, w_game_over_nxt;
  logic       r_winner, w_winner_nxt;

  logic [8:0] w_active_pos, w_enemy_pos, w_cursor_moved, w_step_pos;
  logic [5:0] w_dist, w_range;
  logic       w_enemy_on_path;
  logic [3:0] w_dmg, w_enemy_hp, w_hp_hit;
  logic [4:0] w_cur_x, w_act_x, w_dst_x;
  logic [3:0] w_cur_y, w_act_y, w_dst_y;
  logic       w_do_cancel, w_do_ok, w_arrow_en;
  logic       w_do_up, w_do_down, w_do_left, w_do_right;
  logic [2:0] w_atk_frame;
  logic [2:0] w_idle_frame;

  assign w_active_pos = r_turn ? r_wizard_pos : r_knight_pos;
  assign w_enemy_pos  = r_turn ? r_knight_pos : r_wizard_pos;
  assign w_range      = r_turn ? c_wizard_range : c_knight_range;
  assign w_dmg        = r_turn ? c_wizard_dmg : c_knight_dmg;
  assign w_enemy_hp   = r_turn ? r_knight_hp : r_wizard_hp;
  assign w_hp_hit     = (w_enemy_hp > w_dmg) ? (w_enemy_hp - w_dmg) : 4'd0;

  grid_path_check u_path_check (
    .i_src           (r_src),
    .i_cursor        (r_selected_pos),
    .i_enemy         (w_enemy_pos),
    .o_dist          (w_dist),
    .o_enemy_on_path (w_enemy_on_path)
  );

  // Priority decode: exactly one action (or none) survives per cycle
  assign w_do_cancel = btn_cancel;
  assign w_do_ok     = btn_ok & ~btn_cancel;
  assign w_arrow_en  = ~btn_cancel & ~btn_ok;
  assign w_do_up     = w_arrow_en & btn_up;
  assign w_do_down   = w_arrow_en & ~btn_up & btn_down;
  assign w_do_left   = w_arrow_en & ~btn_up & ~btn_down & btn_left;
  assign w_do_right  = w_arrow_en & ~btn_up & ~btn_down & ~btn_left & btn_right;

  assign w_cur_x = tile_x(r_selected_pos);
  assign w_cur_y = tile_y(r_selected_pos);
  assign w_act_x = tile_x(w_active_pos);
  assign w_act_y = tile_y(w_active_pos);
  assign w_dst_x = tile_x(r_dst);
  assign w_dst_y = tile_y(r_dst);

  // Cursor after the decoded arrow; edge presses leave it in place
  always_comb begin
    w_cursor_moved = r_selected_pos;
    if (w_do_up && (w_cur_y != 4'd0))
      w_cursor_moved = r_selected_pos - 9'(GRID_W);
    else if (w_do_down && (w_cur_y != 4'(GRID_H - 1)))
      w_cursor_moved = r_selected_pos + 9'(GRID_W);
    else if (w_do_left && (w_cur_x != 5'd0))
      w_cursor_moved = r_selected_pos - 9'd1;
    else if (w_do_right && (w_cur_x != 5'(GRID_W - 1)))
      w_cursor_moved = r_selected_pos + 9'd1;
  end

  // One movement step toward dst, columns first
  always_comb begin
    w_step_pos = w_active_pos;
    if (w_act_x < w_dst_x)
      w_step_pos = w_active_pos + 9'd1;
    else if (w_act_x > w_dst_x)
      w_step_pos = w_active_pos - 9'd1;
    else if (w_act_y < w_dst_y)
      w_step_pos = w_active_pos + 9'(GRID_W);
    else if (w_act_y > w_dst_y)
      w_step_pos = w_active_pos - 9'(GRID_W);
  end

  assign w_anim_cnt_nxt = r_anim_cnt + 4'(anim_tick);

  always_comb begin
    w_state_nxt        = r_state;
    w_turn_nxt         = r_turn;
    w_selected_pos_nxt = r_selected_pos;
    w_knight_pos_nxt   = r_knight_pos;
    w_wizard_pos_nxt   = r_wizard_pos;
    w_src_nxt          = r_src;
    w_dst_nxt          = r_dst;
    w_knight_hp_nxt    = r_knight_hp;
    w_wizard_hp_nxt    = r_wizard_hp;
    w_tick_cnt_nxt     = r_tick_cnt;
    w_invalid_nxt      = 1'b0;
    w_game_over_nxt    = r_game_over;
    w_winner_nxt       = r_winner;

    case (r_state)
      CURSOR: begin
        if (w_do_ok) begin
          if (r_selected_pos == w_active_pos) begin
            w_state_nxt = UNIT_SEL;
            w_src_nxt   = r_selected_pos;
          end else begin
            w_invalid_nxt = 1'b1;
          end
        end else begin
          w_selected_pos_nxt = w_cursor_moved;
        end
      end

      UNIT_SEL: begin
        if (w_do_cancel) begin
          w_state_nxt = CURSOR;
        end else if (w_do_ok) begin
          if (r_selected_pos == r_src) begin
            w_state_nxt = END_TURN;
          end else if ((r_selected_pos == w_enemy_pos) && (w_dist <= w_range)) begin
            w_state_nxt    = ATTACK;
            w_tick_cnt_nxt = 8'd0;
          end else if ((r_selected_pos != w_enemy_pos) && (w_dist <= c_move_range) &&
                       !w_enemy_on_path) begin
            w_state_nxt = MOVE;
            w_dst_nxt   = r_selected_pos;
          end else begin
            w_invalid_nxt = 1'b1;
          end
        end else begin
          w_selected_pos_nxt = w_cursor_moved;
        end
      end

      MOVE: begin
        if (anim_tick) begin
          if (r_turn == UNIT_WIZARD) w_wizard_pos_nxt = w_step_pos;
          else                       w_knight_pos_nxt = w_step_pos;
          if (w_step_pos == r_dst) w_state_nxt = END_TURN;
        end
      end

      ATTACK: begin
        if (anim_tick) begin
          if (r_tick_cnt == c_last_tick) begin
            if (r_turn == UNIT_WIZARD) w_knight_hp_nxt = w_hp_hit;
            else                       w_wizard_hp_nxt = w_hp_hit;
            if (w_hp_hit == 4'd0) begin
              w_state_nxt     = GAME_OVER;
              w_game_over_nxt = 1'b1;
              w_winner_nxt    = r_turn;
            end else begin
              w_state_nxt = END_TURN;
            end
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + 8'd1;
          end
        end
      end

      END_TURN: begin
        w_turn_nxt         = ~r_turn;
        w_selected_pos_nxt = r_turn ? r_knight_pos : r_wizard_pos;
        w_state_nxt        = CURSOR;
      end

      GAME_OVER: begin
        w_state_nxt = GAME_OVER;
      end

      default: begin
        w_state_nxt = CURSOR;
      end
    endcase

    // Frames are derived from next-cycle counters so the registered
    // outputs line up with the registered state they belong to.
    w_idle_frame = {2'b00, w_anim_cnt_nxt[3]};
    w_atk_frame  = 3'(32'd2 + 32'(w_tick_cnt_nxt) / TICKS_PER_FRAME);
    w_knight_anim_nxt = w_idle_frame;
    w_wizard_anim_nxt = w_idle_frame;
    if (w_state_nxt == ATTACK) begin
      if (r_turn == UNIT_WIZARD) w_wizard_anim_nxt = w_atk_frame;
      else                       w_knight_anim_nxt = w_atk_frame;
    end
  end

  always_ff @(posedge clk_25MHz or negedge rst) begin
    if (!rst) begin
      r_state        <= CURSOR;
      r_turn         <= UNIT_KNIGHT;
      r_selected_pos <= CURSOR_POS_RST;
      r_knight_pos   <= KNIGHT_POS_RST;
      r_wizard_pos   <= WIZARD_POS_RST;
      r_src          <= CURSOR_POS_RST;
      r_dst          <= CURSOR_POS_RST;
      r_knight_hp    <= c_hp_init;
      r_wizard_hp    <= c_hp_init;
      r_anim_cnt     <= 4'd0;
      r_tick_cnt     <= 8'd0;
      r_knight_anim  <= 3'd0;
      r_wizard_anim  <= 3'd0;
      r_invalid      <= 1'b0;
      r_game_over    <= 1'b0;
      r_winner       <= UNIT_KNIGHT;
    end else begin
      r_state        <= w_state_nxt;
      r_turn         <= w_turn_nxt;
      r_selected_pos <= w_selected_pos_nxt;
      r_knight_pos   <= w_knight_pos_nxt;
      r_wizard_pos   <= w_wizard_pos_nxt;
      r_src          <= w_src_nxt;
      r_dst          <= w_dst_nxt;
      r_knight_hp    <= w_knight_hp_nxt;
      r_wizard_hp    <= w_wizard_hp_nxt;
      r_anim_cnt     <= w_anim_cnt_nxt;
      r_tick_cnt     <= w_tick_cnt_nxt;
      r_knight_anim  <= w_knight_anim_nxt;
      r_wizard_anim  <= w_wizard_anim_nxt;
      r_invalid      <= w_invalid_nxt;
      r_game_over    <= w_game_over_nxt;
      r_winner       <= w_winner_nxt;
    end
  end

  assign selected_pos = r_selected_pos;
  assign knight_pos   = r_knight_pos;
  assign wizard_pos   = r_wizard_pos;
  assign knight_anim  = r_knight_anim;
  assign wizard_anim  = r_wizard_anim;
  assign knight_hp    = r_knight_hp;
  assign wizard_hp    = r_wizard_hp;
  assign turn         = r_turn;
  assign invalid      = r_invalid;
  assign game_over    = r_game_over;
  assign winner       = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_turn_action_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_turn_action_ctrl                                      |
// | Description : Self-checking bench for turn_action_ctrl: directed game  |
// |               scenarios followed by steered random play, compared     |
// |               each cycle against a rules-level game model.            |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_turn_action_ctrl;

  localparam int B_UP = 0, B_DOWN = 1, B_LEFT = 2, B_RIGHT = 3, B_OK = 4, B_CANCEL = 5;
  localparam int M_CUR = 0, M_SEL = 1, M_MOVE = 2, M_ATK = 3, M_END = 4, M_OVER = 5;

  logic       clk_25MHz = 1'b0;
  logic       rst = 1'b0;
  logic       anim_tick = 1'b0;
  logic [5:0] btn = 6'd0;
  logic [8:0] selected_pos, knight_pos, wizard_pos;
  logic [2:0] knight_anim, wizard_anim;
  logic [3:0] knight_hp, wizard_hp;
  logic       turn, invalid, game_over, winner;

  always #20 clk_25MHz = ~clk_25MHz;

  turn_action_ctrl dut (
    .clk_25MHz    (clk_25MHz),
    .rst          (rst),
    .anim_tick    (anim_tick),
    .btn_up       (btn[B_UP]),
    .btn_down     (btn[B_DOWN]),
    .btn_left     (btn[B_LEFT]),
    .btn_right    (btn[B_RIGHT]),
    .btn_ok       (btn[B_OK]),
    .btn_cancel   (btn[B_CANCEL]),
    .selected_pos (selected_pos),
    .knight_pos   (knight_pos),
    .wizard_pos   (wizard_pos),
    .knight_anim  (knight_anim),
    .wizard_anim  (wizard_anim),
    .knight_hp    (knight_hp),
    .wizard_hp    (wizard_hp),
    .turn         (turn),
    .invalid      (invalid),
    .game_over    (game_over),
    .winner       (winner)
  );

  // ---------------- game model (index 0 = knight, 1 = wizard) ----------
  int m_sel = 125, m_turn = 0, m_cnt = 0, m_mode = M_CUR;
  int m_src = 125, m_dst = 125, m_ticks = 0;
  int m_inv = 0, m_go = 0, m_win = 0;
  int m_pos [2] = '{125, 167};
  int m_hp  [2] = '{10, 10};
  int errors = 0, checks = 0;
  bit chk_en = 1'b1;

  function automatic int px(int p); return p % 20; endfunction
  function automatic int py(int p); return p / 20; endfunction
  function automatic int iabs(int v); return (v < 0) ? -v : v; endfunction
  function automatic int mdist(int a, int b);
    return iabs(px(a) - px(b)) + iabs(py(a) - py(b));
  endfunction

  // Walk the L-path tile by tile (row first, then column)
  function automatic bit enemy_on_l(int s, int d, int e);
    int x, y;
    x = px(s); y = py(s);
    while (x != px(d)) begin
      x += (px(d) > x) ? 1 : -1;
      if (x + 20 * y == e) return 1'b1;
    end
    while (y != py(d)) begin
      y += (py(d) > y) ? 1 : -1;
      if (x + 20 * y == e) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int cursor_after(int p, int act);
    if (act == B_UP    && py(p) > 0)  return p - 20;
    if (act == B_DOWN  && py(p) < 14) return p + 20;
    if (act == B_LEFT  && px(p) > 0)  return p - 1;
    if (act == B_RIGHT && px(p) < 19) return p + 1;
    return p;
  endfunction

  function automatic int exp_anim(int u);
    if (m_mode == M_ATK && m_turn == u) return 2 + m_ticks / 4;
    return (m_cnt >= 8) ? 1 : 0;
  endfunction

  task automatic model_step(input logic rst_v, input logic tk, input logic [5:0] b);
    int act, a, e, d, hp, rng, dmg;
    if (!rst_v) begin
      m_sel = 125; m_pos[0] = 125; m_pos[1] = 167; m_hp[0] = 10; m_hp[1] = 10;
      m_turn = 0; m_cnt = 0; m_mode = M_CUR; m_inv = 0; m_go = 0; m_win = 0;
      return;
    end
    m_inv = 0;
    act = -1;
    if (b[B_CANCEL]) act = B_CANCEL;
    else if (b[B_OK]) act = B_OK;
    else if (b[B_UP]) act = B_UP;
    else if (b[B_DOWN]) act = B_DOWN;
    else if (b[B_LEFT]) act = B_LEFT;
    else if (b[B_RIGHT]) act = B_RIGHT;
    a = m_pos[m_turn];
    e = m_pos[1 - m_turn];
    rng = (m_turn == 1) ? 3 : 1;
    dmg = (m_turn == 1) ? 2 : 3;
    if (tk) m_cnt = (m_cnt + 1) % 16;
    case (m_mode)
      M_CUR: begin
        if (act == B_OK) begin
          if (m_sel == a) begin m_mode = M_SEL; m_src = m_sel; end
          else m_inv = 1;
        end else if (act >= B_UP && act <= B_RIGHT) m_sel = cursor_after(m_sel, act);
      end
      M_SEL: begin
        if (act == B_CANCEL) m_mode = M_CUR;
        else if (act == B_OK) begin
          d = mdist(m_src, m_sel);
          if (m_sel == m_src) m_mode = M_END;
          else if (m_sel == e && d <= rng) begin m_mode = M_ATK; m_ticks = 0; end
          else if (m_sel != e && d <= 3 && !enemy_on_l(m_src, m_sel, e)) begin
            m_mode = M_MOVE; m_dst = m_sel;
          end else m_inv = 1;
        end else if (act >= B_UP) m_sel = cursor_after(m_sel, act);
      end
      M_MOVE: begin
        if (tk) begin
          if (px(a) != px(m_dst)) a += (px(m_dst) > px(a)) ? 1 : -1;
          else a += (py(m_dst) > py(a)) ? 20 : -20;
          m_pos[m_turn] = a;
          if (a == m_dst) m_mode = M_END;
        end
      end
      M_ATK: begin
        if (tk) begin
          m_ticks++;
          if (m_ticks == 16) begin
            hp = m_hp[1 - m_turn] - dmg;
            if (hp < 0) hp = 0;
            m_hp[1 - m_turn] = hp;
            if (hp == 0) begin m_mode = M_OVER; m_go = 1; m_win = m_turn; end
            else m_mode = M_END;
          end
        end
      end
      M_END: begin
        m_turn = 1 - m_turn;
        m_sel = m_pos[m_turn];
        m_mode = M_CUR;
      end
      default: ;
    endcase
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk_25MHz) begin
    if (chk_en) begin
      chk("selected_pos", int'(selected_pos), m_sel);
      chk("knight_pos", int'(knight_pos), m_pos[0]);
      chk("wizard_pos", int'(wizard_pos), m_pos[1]);
      chk("knight_hp", int'(knight_hp), m_hp[0]);
      chk("wizard_hp", int'(wizard_hp), m_hp[1]);
      chk("knight_anim", int'(knight_anim), exp_anim(0));
      chk("wizard_anim", int'(wizard_anim), exp_anim(1));
      chk("turn", int'(turn), m_turn);
      chk("invalid", int'(invalid), m_inv);
      chk("game_over", int'(game_over), m_go);
      if (m_go != 0) chk("winner", int'(winner), m_win);
    end
  end

  // ---------------- stimulus helpers ------------------------------------
  task automatic cyc(input logic [5:0] b, input logic tk);
    btn = b;
    anim_tick = tk;
    @(posedge clk_25MHz);
    model_step(rst, tk, b);
    @(negedge clk_25MHz);
  endtask

  task automatic press(input int idx);
    logic [5:0] v;
    v = 6'd0;
    v[idx] = 1'b1;
    cyc(v, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(6'd0, 1'b1);
  endtask

  task automatic goto(input int target);
    for (int i = 0; i < 64 && m_sel != target; i++) begin
      if (px(m_sel) < px(target)) press(B_RIGHT);
      else if (px(m_sel) > px(target)) press(B_LEFT);
      else if (py(m_sel) < py(target)) press(B_DOWN);
      else press(B_UP);
    end
  endtask

  task automatic knight_move_to_147();
    goto(125); press(B_OK); press(B_RIGHT); press(B_RIGHT); press(B_DOWN); press(B_OK);
  endtask

  task automatic wizard_wait();
    goto(m_pos[1]); press(B_OK); press(B_OK); cyc(6'd0, 1'b0);
  endtask

  int hp_table [4] = '{7, 4, 1, 0};
  int tgt = 0, last_mode = -1;

  initial begin
    // Reset
    rst = 1'b0;
    cyc(6'd0, 1'b0);
    chk("rst selected_pos", int'(selected_pos), 125);
    chk("rst knight_pos", int'(knight_pos), 125);
    chk("rst wizard_pos", int'(wizard_pos), 167);
    chk("rst hp", int'({knight_hp, wizard_hp}), 8'hAA);
    chk("rst turn", int'(turn), 0);
    rst = 1'b1;
    cyc(6'd0, 1'b0);

    // Idle animation
    ticks(7);
    chk("idle anim cnt7", int'(knight_anim), 0);
    ticks(1);
    chk("idle anim cnt8", int'(wizard_anim), 1);
    ticks(8);
    chk("idle anim wrap", int'(knight_anim), 0);

    // Cursor clamps
    goto(0);
    press(B_LEFT); chk("clamp left", int'(selected_pos), 0);
    press(B_UP);   chk("clamp up", int'(selected_pos), 0);
    goto(299);
    press(B_RIGHT); chk("clamp right", int'(selected_pos), 299);
    press(B_DOWN);  chk("clamp down", int'(selected_pos), 299);

    // Knight move 125 -> 147
    knight_move_to_147();
    ticks(1); chk("move step1", int'(knight_pos), 126);
    ticks(1); chk("move step2", int'(knight_pos), 127);
    ticks(1); chk("move step3", int'(knight_pos), 147);
    cyc(6'd0, 1'b0);
    chk("end turn", int'(turn), 1);
    chk("end turn sel", int'(selected_pos), 167);

    // Invalid commands on the wizard's turn
    press(B_OK);
    goto(171); press(B_OK);
    chk("invalid far", int'(invalid), 1);
    cyc(6'd0, 1'b0);
    chk("invalid pulse", int'(invalid), 0);
    goto(127); press(B_OK);
    chk("invalid L-path", int'(invalid), 1);
    chk("invalid keeps pos", int'(wizard_pos), 167);
    press(B_CANCEL);
    goto(0); press(B_OK);
    chk("invalid ok@0", int'(invalid), 1);
    wizard_wait();
    chk("back to knight", int'(selected_pos), 147);

    // Knight attacks until the wizard falls
    for (int k = 0; k < 4; k++) begin
      goto(147); press(B_OK); press(B_DOWN); press(B_OK);
      chk("atk frame2", int'(knight_anim), 2);
      ticks(4); chk("atk frame3", int'(knight_anim), 3);
      ticks(4); chk("atk frame4", int'(knight_anim), 4);
      ticks(4); chk("atk frame5", int'(knight_anim), 5);
      ticks(4); chk("atk wizard_hp", int'(wizard_hp), hp_table[k]);
      if (k < 3) begin
        cyc(6'd0, 1'b0);
        chk("atk turn", int'(turn), 1);
        wizard_wait();
      end
    end
    chk("game_over", int'(game_over), 1);
    chk("winner", int'(winner), 0);
    cyc(6'h3f, 1'b1); press(B_OK); press(B_LEFT); press(B_CANCEL);
    chk("over frozen sel", int'(selected_pos), 167);

    // Reset in the middle of an attack
    rst = 1'b0; cyc(6'd0, 1'b0); rst = 1'b1;
    knight_move_to_147(); ticks(3); cyc(6'd0, 1'b0);
    wizard_wait();
    press(B_OK); press(B_DOWN); press(B_OK);
    ticks(9);
    rst = 1'b0;
    cyc(6'd0, 1'b0);
    chk("midatk rst wizard_hp", int'(wizard_hp), 10);
    chk("midatk rst knight_pos", int'(knight_pos), 125);
    chk("midatk rst anim", int'(knight_anim), 0);
    rst = 1'b1;

    // Steered random play
    for (int i = 0; i < 6000; i++) begin
      logic [5:0] b;
      logic tk;
      int r;
      if (m_mode != last_mode) begin
        if (m_mode == M_SEL) begin
          if ($urandom_range(0, 2) == 0) tgt = m_pos[1 - m_turn];
          else begin
            int tx, ty;
            tx = px(m_src) + $urandom_range(0, 6) - 3;
            ty = py(m_src) + $urandom_range(0, 6) - 3;
            tx = (tx < 0) ? 0 : (tx > 19) ? 19 : tx;
            ty = (ty < 0) ? 0 : (ty > 14) ? 14 : ty;
            tgt = tx + 20 * ty;
          end
        end else tgt = m_pos[m_turn];
        last_mode = m_mode;
      end
      tk = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 99);
      b = 6'd0;
      if (r < 45) begin
        if (m_sel == tgt) b[B_OK] = 1'b1;
        else if (px(m_sel) < px(tgt)) b[B_RIGHT] = 1'b1;
        else if (px(m_sel) > px(tgt)) b[B_LEFT] = 1'b1;
        else if (py(m_sel) < py(tgt)) b[B_DOWN] = 1'b1;
        else b[B_UP] = 1'b1;
      end else if (r < 80) b = 6'd0;
      else if (r < 93) b[$urandom_range(0, 5)] = 1'b1;
      else b = 6'($urandom);
      rst = ((m_go != 0 && $urandom_range(0, 9) == 0) || $urandom_range(0, 1499) == 0) ? 1'b0 : 1'b1;
      cyc(b, tk);
    end
    rst = 1'b1;
    cyc(6'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
